// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory access sequencer: op codes, FSM states
// and requester identifiers.
package dmem_pkg;

  localparam logic [1:0] OP_NOP = 2'b00;
  localparam logic [1:0] OP_LDR = 2'b01;
  localparam logic [1:0] OP_STR = 2'b10;
  localparam logic [1:0] OP_SWP = 2'b11;

  localparam logic REQ_PIPE = 1'b0;
  localparam logic REQ_DBG  = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RD     = 3'd1,
    ST_WR     = 3'd2,
    ST_SWP_RD = 3'd3,
    ST_SWP_WR = 3'd4,
    ST_RESP   = 3'd5
  } state_e;

  function automatic logic is_mem_op(input logic [1:0] op);
    return (op != OP_NOP);
  endfunction

endpackage

// File: rtl/dmem_grant_arb.sv
// Grant arbiter for the data-memory sequencer: pipeline priority, with a
// starvation counter that hands the next grant to debug after STARVE_LIMIT losses.
module dmem_grant_arb
  import dmem_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic arb_en,
  input  logic req_p,
  input  logic req_d,
  output logic grant_p,
  output logic grant_d
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0] starve_cnt_r;
  logic       starved_s;

  // Grant decision, only while the sequencer is idle
  always_comb begin
    starved_s = (starve_cnt_r == LIMIT);
    grant_p   = 1'b0;
    grant_d   = 1'b0;
    if (arb_en) begin
      grant_d = req_d & (~req_p | starved_s);
      grant_p = req_p & ~grant_d;
    end else begin
      grant_p = 1'b0;
      grant_d = 1'b0;
    end
  end

  // Debug loss counter: counts idle-cycle losses, saturates, clears on a debug grant
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt_r <= 4'd0;
    end else if (grant_d) begin
      starve_cnt_r <= 4'd0;
    end else if (arb_en && req_d && !starved_s) begin
      starve_cnt_r <= starve_cnt_r + 4'd1;
    end else begin
      starve_cnt_r <= starve_cnt_r;
    end
  end

endmodule

// File: rtl/dmem_access_sequencer.sv
// Serialises pipeline (LDR/STR/SWP) and debug (word read/write) accesses to data_mem,
// running SWP as an uninterruptible read-then-write and stalling the pipeline while busy.
module dmem_access_sequencer
  import dmem_pkg::*;
#(
  parameter int AW           = 32,
  parameter int DW           = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          p_valid,
  input  logic [1:0]    p_op,
  input  logic [AW-1:0] p_addr,
  input  logic [DW-1:0] p_wdata,
  output logic          p_ready,
  output logic          p_rvalid,
  output logic [DW-1:0] p_rdata,
  output logic          stall,
  input  logic          d_valid,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_ready,
  output logic          d_rvalid,
  output logic [DW-1:0] d_rdata,
  output logic          mem_read,
  output logic          mem_write,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  state_e        state_r;
  logic          owner_r;
  logic [DW-1:0] wdata_r;
  logic [DW-1:0] old_r;
  logic          arb_en_s;
  logic          req_p_s;
  logic          grant_p_s;
  logic          grant_d_s;

  assign arb_en_s = (state_r == ST_IDLE);
  assign req_p_s  = p_valid & is_mem_op(p_op);
  assign p_ready  = grant_p_s;
  assign d_ready  = grant_d_s;
  assign stall    = req_p_s & ~grant_p_s;

  dmem_grant_arb #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .arb_en (arb_en_s),
    .req_p  (req_p_s),
    .req_d  (d_valid),
    .grant_p(grant_p_s),
    .grant_d(grant_d_s)
  );

  // Sequencer FSM; memory strobes and read returns are registered so each state drives them
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      owner_r   <= REQ_PIPE;
      wdata_r   <= {DW{1'b0}};
      old_r     <= {DW{1'b0}};
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      mem_addr  <= {AW{1'b0}};
      mem_wdata <= {DW{1'b0}};
      p_rvalid  <= 1'b0;
      p_rdata   <= {DW{1'b0}};
      d_rvalid  <= 1'b0;
      d_rdata   <= {DW{1'b0}};
    end else begin
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      p_rvalid  <= 1'b0;
      d_rvalid  <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (grant_p_s) begin
            owner_r  <= REQ_PIPE;
            wdata_r  <= p_wdata;
            mem_addr <= p_addr;
            case (p_op)
              OP_LDR: begin
                state_r  <= ST_RD;
                mem_read <= 1'b1;
              end
              OP_STR: begin
                state_r   <= ST_WR;
                mem_write <= 1'b1;
                mem_wdata <= p_wdata;
              end
              OP_SWP: begin
                state_r  <= ST_SWP_RD;
                mem_read <= 1'b1;
              end
              default: state_r <= ST_IDLE;
            endcase
          end else if (grant_d_s) begin
            owner_r  <= REQ_DBG;
            wdata_r  <= d_wdata;
            mem_addr <= d_addr;
            if (d_we) begin
              state_r   <= ST_WR;
              mem_write <= 1'b1;
              mem_wdata <= d_wdata;
            end else begin
              state_r  <= ST_RD;
              mem_read <= 1'b1;
            end
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_RD: begin
          state_r <= ST_RESP;
          if (owner_r == REQ_DBG) begin
            d_rvalid <= 1'b1;
            d_rdata  <= mem_rdata;
          end else begin
            p_rvalid <= 1'b1;
            p_rdata  <= mem_rdata;
          end
        end
        ST_WR: state_r <= ST_IDLE;
        // Old value is kept aside and returned only after the new value is written
        ST_SWP_RD: begin
          state_r   <= ST_SWP_WR;
          old_r     <= mem_rdata;
          mem_write <= 1'b1;
          mem_wdata <= wdata_r;
        end
        ST_SWP_WR: begin
          state_r  <= ST_RESP;
          p_rvalid <= 1'b1;
          p_rdata  <= old_r;
        end
        ST_RESP: state_r <= ST_IDLE;
        default: state_r <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_access_sequencer.sv
// Self-checking bench for dmem_access_sequencer: directed vector table, multi-cycle
// corner sequences and a randomized run against a transaction-level reference model.
module tb_dmem_access_sequencer;

  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        p_valid;
  logic [1:0]  p_op;
  logic [31:0] p_addr;
  logic [31:0] p_wdata;
  logic        p_ready;
  logic        p_rvalid;
  logic [31:0] p_rdata;
  logic        stall;
  logic        d_valid;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_ready;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  int pass_cnt = 0;
  int chk_cnt  = 0;
  int overlap_n = 0;

  dmem_access_sequencer #(.AW(32), .DW(32), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .p_valid(p_valid), .p_op(p_op), .p_addr(p_addr), .p_wdata(p_wdata),
    .p_ready(p_ready), .p_rvalid(p_rvalid), .p_rdata(p_rdata), .stall(stall),
    .d_valid(d_valid), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ready(d_ready), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Small data_mem: combinational read, write at clock edge, plus a backdoor preload port
  logic [31:0] mem [16];
  logic        pre_en = 1'b0;
  logic        mem_clr = 1'b0;
  logic [3:0]  pre_addr = 4'd0;
  logic [31:0] pre_data = 32'd0;
  assign mem_rdata = mem[mem_addr[3:0]];
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 16; i++) mem[i] <= 32'd0;
    end else if (mem_write) begin
      mem[mem_addr[3:0]] <= mem_wdata;
    end else if (pre_en) begin
      mem[pre_addr] <= pre_data;
    end
  end

  always @(negedge clk) if (rst_n && mem_read && mem_write) overlap_n++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; p_valid = 1'b0; p_op = 2'b00; p_addr = 32'd0; p_wdata = 32'd0;
    d_valid = 1'b0; d_we = 1'b0; d_addr = 32'd0; d_wdata = 32'd0;
    mem_clr = 1'b1;
    repeat (2) @(posedge clk);
    #1 mem_clr = 1'b0; rst_n = 1'b1;
  endtask

  task automatic preload(input logic [3:0] a, input logic [31:0] d);
    pre_en = 1'b1; pre_addr = a; pre_data = d;
    @(posedge clk);
    #1 pre_en = 1'b0;
  endtask

  typedef struct {
    logic        dbg;
    logic [1:0]  op;
    logic        we;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic [31:0] pre;
    int          rd_off;
    int          wr_off;
    int          rv_off;
    logic [31:0] exp_rdata;
    logic [31:0] exp_mem;
  } vec_t;

  vec_t vecs [6];

  // One isolated transaction from idle; offsets are cycles after the accept cycle
  task automatic run_vec(input vec_t v, input int idx);
    int rd_c, wr_c, rv_c;
    logic [31:0] rv_d;
    rd_c = -1; wr_c = -1; rv_c = -1; rv_d = 32'd0;
    preload(v.addr, v.pre);
    if (v.dbg) begin
      d_valid = 1'b1; d_we = v.we; d_addr = {28'd0, v.addr}; d_wdata = v.wdata;
    end else begin
      p_valid = 1'b1; p_op = v.op; p_addr = {28'd0, v.addr}; p_wdata = v.wdata;
    end
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (k == 0) check($sformatf("vec%0d_ready", idx), v.dbg ? d_ready : p_ready, 32'd1);
      if (mem_read && rd_c < 0) rd_c = k;
      if (mem_write && wr_c < 0) wr_c = k;
      if ((v.dbg ? d_rvalid : p_rvalid) && rv_c < 0) begin
        rv_c = k;
        rv_d = v.dbg ? d_rdata : p_rdata;
      end
      @(posedge clk);
      #1 p_valid = 1'b0; d_valid = 1'b0;
    end
    check($sformatf("vec%0d_rd_cycle", idx), rd_c, v.rd_off);
    check($sformatf("vec%0d_wr_cycle", idx), wr_c, v.wr_off);
    check($sformatf("vec%0d_rvalid_cycle", idx), rv_c, v.rv_off);
    if (rv_c >= 0) check($sformatf("vec%0d_rdata", idx), rv_d, v.exp_rdata);
    check($sformatf("vec%0d_mem", idx), mem[v.addr], v.exp_mem);
  endtask

  // Random-phase reference model state
  logic [31:0] ref_mem [8];
  int          m_cnt, free_at, pexp_c, dexp_c;
  logic [31:0] pexp_d, dexp_d;
  logic        p_pend, d_pend, gp, gd, idle;

  initial begin
    int stall_n, acc, rv_k, first, nwin, wr_seen;
    int win [10];
    logic [31:0] rv_data;

    vecs[0] = '{1'b0, 2'b01, 1'b0, 4'd1,  32'h0000_0000, 32'hFFFF_1100, 1, -1,  2, 32'hFFFF_1100, 32'hFFFF_1100};
    vecs[1] = '{1'b0, 2'b10, 1'b0, 4'd2,  32'h0000_1212, 32'h0000_0000, -1, 1, -1, 32'h0000_0000, 32'h0000_1212};
    vecs[2] = '{1'b0, 2'b11, 1'b0, 4'd1,  32'h0000_1212, 32'hFFFF_1100, 1,  2,  3, 32'hFFFF_1100, 32'h0000_1212};
    vecs[3] = '{1'b1, 2'b00, 1'b0, 4'd3,  32'h0000_0000, 32'hA5A5_5A5A, 1, -1,  2, 32'hA5A5_5A5A, 32'hA5A5_5A5A};
    vecs[4] = '{1'b1, 2'b00, 1'b1, 4'd4,  32'hDEAD_BEEF, 32'h0000_0000, -1, 1, -1, 32'h0000_0000, 32'hDEAD_BEEF};
    vecs[5] = '{1'b0, 2'b11, 1'b0, 4'd15, 32'h0000_0000, 32'hFFFF_FFFF, 1,  2,  3, 32'hFFFF_FFFF, 32'h0000_0000};

    do_reset();
    @(negedge clk);
    check("reset_outputs", {p_ready, p_rvalid, stall, d_ready, d_rvalid, mem_read, mem_write}, 32'd0);
    check("reset_p_rdata", p_rdata, 32'd0);
    check("reset_d_rdata", d_rdata, 32'd0);
    check("reset_mem_addr", mem_addr, 32'd0);
    check("reset_mem_wdata", mem_wdata, 32'd0);

    for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

    // STR then back-to-back LDR to the same address: one stall cycle, new data returned
    p_valid = 1'b1; p_op = 2'b10; p_addr = 32'd1; p_wdata = 32'h0000_1212;
    @(negedge clk);
    check("str_accept", p_ready, 32'd1);
    @(posedge clk);
    #1 p_op = 2'b01;
    stall_n = 0; acc = -1; rv_k = -1; rv_data = 32'd0;
    for (int k = 1; k < 9; k++) begin
      @(negedge clk);
      if (stall) stall_n++;
      if (p_ready && acc < 0) acc = k;
      if (p_rvalid && rv_k < 0) begin rv_k = k; rv_data = p_rdata; end
      @(posedge clk);
      #1 if (acc >= 0) p_valid = 1'b0;
    end
    check("stall_cycles", stall_n, 32'd1);
    check("ldr_accept_cycle", acc, 32'd2);
    check("ldr_rvalid_cycle", rv_k, 32'd4);
    check("ldr_after_str_data", rv_data, 32'h0000_1212);

    // Reset while in SWP_RD: write must never be issued
    preload(4'd1, 32'hFFFF_1100);
    p_valid = 1'b1; p_op = 2'b11; p_addr = 32'd1; p_wdata = 32'h0000_1212;
    @(negedge clk);
    check("swp_rst_accept", p_ready, 32'd1);
    @(posedge clk);
    #1 p_valid = 1'b0;
    @(negedge clk);
    check("swp_rst_read", mem_read, 32'd1);
    rst_n = 1'b0;
    #1;
    check("swp_rst_outputs", {p_ready, p_rvalid, stall, d_ready, d_rvalid, mem_read, mem_write}, 32'd0);
    check("swp_rst_p_rdata", p_rdata, 32'd0);
    wr_seen = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (mem_write || p_rvalid) wr_seen++;
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (mem_write || p_rvalid) wr_seen++;
    end
    check("swp_rst_no_write", wr_seen, 32'd0);
    check("swp_rst_mem", mem[1], 32'hFFFF_1100);

    // Debug request arriving during SWP_RD waits until the sequencer is idle again
    @(posedge clk);
    #1 p_valid = 1'b1; p_op = 2'b11; p_addr = 32'd2; p_wdata = 32'h0000_0077;
    @(negedge clk);
    check("swp_dbg_accept", p_ready, 32'd1);
    @(posedge clk);
    #1 p_valid = 1'b0; d_valid = 1'b1; d_we = 1'b0; d_addr = 32'd5;
    first = -1;
    for (int k = 1; k < 9; k++) begin
      @(negedge clk);
      if (d_ready && first < 0) first = k;
      @(posedge clk);
      #1 if (first >= 0) d_valid = 1'b0;
    end
    check("swp_dbg_first_ready", first, 32'd4);
    check("swp_dbg_mem", mem[2], 32'h0000_0077);

    // Starvation: both held continuously; pattern P P P P D repeats
    do_reset();
    p_valid = 1'b1; p_op = 2'b10; p_addr = 32'd6; p_wdata = 32'h0000_0066;
    d_valid = 1'b1; d_we = 1'b1; d_addr = 32'd7; d_wdata = 32'h0000_0077;
    nwin = 0;
    for (int k = 0; k < 60 && nwin < 10; k++) begin
      @(negedge clk);
      if (p_ready) begin win[nwin] = 0; nwin++; end
      else if (d_ready) begin win[nwin] = 1; nwin++; end
      @(posedge clk);
      #1;
    end
    p_valid = 1'b0; d_valid = 1'b0;
    check("starve_grant_count", nwin, 32'd10);
    for (int i = 0; i < nwin; i++)
      check($sformatf("starve_winner%0d", i), win[i], ((i % 5) == 4) ? 32'd1 : 32'd0);

    // Randomized run against the transaction-level model
    do_reset();
    for (int i = 0; i < 8; i++) ref_mem[i] = 32'd0;
    m_cnt = 0; free_at = 0; pexp_c = -1; dexp_c = -1;
    pexp_d = 32'd0; dexp_d = 32'd0; p_pend = 1'b0; d_pend = 1'b0;
    for (int c = 0; c < 600; c++) begin
      if (!p_pend && $urandom_range(0, 2) != 0) begin
        p_pend = 1'b1;
        p_op = 2'($urandom_range(1, 3));
        p_addr = 32'($urandom_range(0, 7));
        p_wdata = $urandom;
      end
      if (!d_pend && $urandom_range(0, 2) == 0) begin
        d_pend = 1'b1;
        d_we = 1'($urandom_range(0, 1));
        d_addr = 32'($urandom_range(0, 7));
        d_wdata = $urandom;
      end
      p_valid = p_pend; d_valid = d_pend;
      @(negedge clk);
      idle = (c >= free_at);
      gd = idle && d_pend && (!p_pend || m_cnt == LIMIT);
      gp = idle && p_pend && !gd;
      check("rnd_p_ready", p_ready, gp);
      check("rnd_d_ready", d_ready, gd);
      check("rnd_stall", stall, p_pend && !gp);
      check("rnd_p_rvalid", p_rvalid, c == pexp_c);
      if (c == pexp_c) check("rnd_p_rdata", p_rdata, pexp_d);
      check("rnd_d_rvalid", d_rvalid, c == dexp_c);
      if (c == dexp_c) check("rnd_d_rdata", d_rdata, dexp_d);
      if (gd) m_cnt = 0;
      else if (idle && d_pend && m_cnt < LIMIT) m_cnt++;
      if (gp) begin
        case (p_op)
          2'b01: begin pexp_c = c + 2; pexp_d = ref_mem[p_addr[2:0]]; free_at = c + 3; end
          2'b10: begin ref_mem[p_addr[2:0]] = p_wdata; free_at = c + 2; end
          default: begin
            pexp_c = c + 3; pexp_d = ref_mem[p_addr[2:0]];
            ref_mem[p_addr[2:0]] = p_wdata; free_at = c + 4;
          end
        endcase
        p_pend = 1'b0;
      end
      if (gd) begin
        if (d_we) begin
          ref_mem[d_addr[2:0]] = d_wdata; free_at = c + 2;
        end else begin
          dexp_c = c + 2; dexp_d = ref_mem[d_addr[2:0]]; free_at = c + 3;
        end
        d_pend = 1'b0;
      end
      @(posedge clk);
      #1;
    end
    p_valid = 1'b0; d_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) check($sformatf("rnd_mem%0d", i), mem[i], ref_mem[i]);
    check("mem_rw_overlap", overlap_n, 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
